// File: rtl/axis_word_serializer_if.sv
// rtl/axis_word_serializer_if.sv - AXI-Stream-like handshake bundle used on both sides of the serializer
interface axis_word_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_word_serializer.sv
// rtl/axis_word_serializer.sv - wide stream word to byte stream serializer, tlast on the final byte
module axis_word_serializer #(
  parameter int WORD_WIDTH = 16,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                           clk,
  input  logic                           arstn,
  axis_word_serializer_if.slave          s_axis,
  axis_word_serializer_if.master         m_axis,
  output logic                           busy
);

  localparam int NBYTES = WORD_WIDTH / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  generate
    if ((WORD_WIDTH % 8) != 0 || WORD_WIDTH < 8) begin : g_bad_width
      $error("axis_word_serializer: WORD_WIDTH must be a non-zero multiple of 8");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [WORD_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    last_q, last_d;
  logic                    rdy_en_q, rdy_en_d;
  logic                    s_ready;
  logic                    s_accept;

  // rdy_en_q keeps s_axis_tready low while in reset even though state is IDLE
  assign s_ready  = rdy_en_q && ((state_q == IDLE) ||
                                 (state_q == SEND && last_q && m_axis.tready));
  assign s_accept = s_ready && s_axis.tvalid;

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = (state_q == SEND);
  assign m_axis.tlast  = last_q;
  assign m_axis.tdata  = MSB_FIRST ? shreg_q[WORD_WIDTH-1 -: 8] : shreg_q[7:0];
  assign busy          = (state_q == SEND);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    last_d   = last_q;
    rdy_en_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (s_accept) begin
          state_d = SEND;
          shreg_d = s_axis.tdata;
          idx_d   = '0;
          last_d  = (NBYTES == 1);
        end
      end
      SEND: begin
        if (m_axis.tready) begin
          if (last_q) begin
            if (s_accept) begin
              shreg_d = s_axis.tdata;
              idx_d   = '0;
              last_d  = (NBYTES == 1);
            end else begin
              state_d = IDLE;
              last_d  = 1'b0;
            end
          end else begin
            shreg_d = MSB_FIRST ? (shreg_q << 8) : (shreg_q >> 8);
            idx_d   = idx_q + 1'b1;
            last_d  = ((idx_q + 1'b1) == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shreg_q  <= '0;
      last_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      last_q   <= last_d;
      rdy_en_q <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_axis_word_serializer.sv
// tb/tb_axis_word_serializer.sv - directed table-driven bench for the word serializer
module tb_axis_word_serializer;

  logic clk;
  logic arstn;
  logic busy24, busy16, busy8;

  axis_word_serializer_if #(.DATA_WIDTH(24)) s24 ();
  axis_word_serializer_if #(.DATA_WIDTH(8))  m24 ();
  axis_word_serializer_if #(.DATA_WIDTH(16)) s16 ();
  axis_word_serializer_if #(.DATA_WIDTH(8))  m16 ();
  axis_word_serializer_if #(.DATA_WIDTH(8))  s8 ();
  axis_word_serializer_if #(.DATA_WIDTH(8))  m8 ();

  axis_word_serializer #(.WORD_WIDTH(24), .MSB_FIRST(1'b1)) dut24 (
    .clk(clk), .arstn(arstn), .s_axis(s24), .m_axis(m24), .busy(busy24));
  axis_word_serializer #(.WORD_WIDTH(16), .MSB_FIRST(1'b0)) dut16 (
    .clk(clk), .arstn(arstn), .s_axis(s16), .m_axis(m16), .busy(busy16));
  axis_word_serializer #(.WORD_WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
    .clk(clk), .arstn(arstn), .s_axis(s8), .m_axis(m8), .busy(busy8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [23:0] sd;
    logic        mr;
    logic        ev;
    logic [7:0]  ed;
    logic        el;
    logic        esr;
    logic        eb;
  } vec_t;

  vec_t tab[$];
  vec_t tab2[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, compare 1ns later; the rising edge then commits the cycle.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    s24.tvalid = v.sv;
    s24.tdata  = v.sd;
    m24.tready = v.mr;
    #1;
    check({tag, ".tvalid"}, 32'(m24.tvalid), 32'(v.ev));
    check({tag, ".tlast"},  32'(m24.tlast),  32'(v.el));
    check({tag, ".s_tready"}, 32'(s24.tready), 32'(v.esr));
    check({tag, ".busy"},   32'(busy24),     32'(v.eb));
    if (v.ev) check({tag, ".tdata"}, 32'(m24.tdata), 32'(v.ed));
  endtask

  initial begin
    arstn = 1'b0;
    s24.tvalid = 0; s24.tdata = '0; s24.tlast = 0; m24.tready = 1;
    s16.tvalid = 0; s16.tdata = '0; s16.tlast = 0; m16.tready = 1;
    s8.tvalid  = 0; s8.tdata  = '0; s8.tlast  = 0; m8.tready  = 1;

    // sv, sd, mr | tvalid, tdata, tlast, s_tready, busy
    tab.push_back(vec_t'{1, 24'hA1B2C3, 1, 0, 8'h00, 0, 1, 0});
    tab.push_back(vec_t'{0, 24'hFFFFFF, 1, 1, 8'hA1, 0, 0, 1});
    tab.push_back(vec_t'{0, 24'hFFFFFF, 1, 1, 8'hB2, 0, 0, 1});
    tab.push_back(vec_t'{0, 24'hFFFFFF, 1, 1, 8'hC3, 1, 1, 1});
    tab.push_back(vec_t'{0, 24'h000000, 1, 0, 8'h00, 0, 1, 0});
    tab.push_back(vec_t'{1, 24'h010203, 1, 0, 8'h00, 0, 1, 0});
    tab.push_back(vec_t'{1, 24'h0A0B0C, 1, 1, 8'h01, 0, 0, 1});
    tab.push_back(vec_t'{1, 24'h0A0B0C, 1, 1, 8'h02, 0, 0, 1});
    tab.push_back(vec_t'{1, 24'h0A0B0C, 1, 1, 8'h03, 1, 1, 1});
    tab.push_back(vec_t'{0, 24'h000000, 1, 1, 8'h0A, 0, 0, 1});
    tab.push_back(vec_t'{0, 24'h000000, 1, 1, 8'h0B, 0, 0, 1});
    tab.push_back(vec_t'{0, 24'h000000, 1, 1, 8'h0C, 1, 1, 1});
    tab.push_back(vec_t'{0, 24'h000000, 1, 0, 8'h00, 0, 1, 0});
    tab.push_back(vec_t'{1, 24'hDEADBE, 1, 0, 8'h00, 0, 1, 0});
    tab.push_back(vec_t'{0, 24'h000000, 1, 1, 8'hDE, 0, 0, 1});
    tab.push_back(vec_t'{1, 24'h123456, 0, 1, 8'hAD, 0, 0, 1});
    tab.push_back(vec_t'{1, 24'h654321, 0, 1, 8'hAD, 0, 0, 1});
    tab.push_back(vec_t'{0, 24'h999999, 1, 1, 8'hAD, 0, 0, 1});
    tab.push_back(vec_t'{1, 24'h777777, 0, 1, 8'hBE, 1, 0, 1});
    tab.push_back(vec_t'{0, 24'h000000, 1, 1, 8'hBE, 1, 1, 1});
    tab.push_back(vec_t'{0, 24'h000000, 1, 0, 8'h00, 0, 1, 0});

    tab2.push_back(vec_t'{1, 24'h445566, 1, 0, 8'h00, 0, 1, 0});
    tab2.push_back(vec_t'{0, 24'h000000, 1, 1, 8'h44, 0, 0, 1});
    tab2.push_back(vec_t'{0, 24'h000000, 1, 1, 8'h55, 0, 0, 1});
    tab2.push_back(vec_t'{0, 24'h000000, 1, 1, 8'h66, 1, 1, 1});
    tab2.push_back(vec_t'{0, 24'h000000, 1, 0, 8'h00, 0, 1, 0});

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst.tvalid",   32'(m24.tvalid), 32'd0);
    check("rst.tlast",    32'(m24.tlast),  32'd0);
    check("rst.tdata",    32'(m24.tdata),  32'd0);
    check("rst.s_tready", 32'(s24.tready), 32'd0);
    check("rst.busy",     32'(busy24),     32'd0);
    check("rst8.s_tready", 32'(s8.tready), 32'd0);
    arstn = 1'b1;

    for (int i = 0; i < tab.size(); i++) apply(tab[i], $sformatf("v%0d", i));

    // Reset in the middle of a word: outputs must drop without a clock edge.
    apply(vec_t'{1, 24'hA1B2C3, 1, 0, 8'h00, 0, 1, 0}, "mid0");
    apply(vec_t'{0, 24'h000000, 1, 1, 8'hA1, 0, 0, 1}, "mid1");
    apply(vec_t'{0, 24'h000000, 1, 1, 8'hB2, 0, 0, 1}, "mid2");
    arstn = 1'b0;
    #1;
    check("mid.rst.tvalid",   32'(m24.tvalid), 32'd0);
    check("mid.rst.busy",     32'(busy24),     32'd0);
    check("mid.rst.s_tready", 32'(s24.tready), 32'd0);
    check("mid.rst.tlast",    32'(m24.tlast),  32'd0);
    check("mid.rst.tdata",    32'(m24.tdata),  32'd0);
    @(negedge clk);
    arstn = 1'b1;
    for (int i = 0; i < tab2.size(); i++) apply(tab2[i], $sformatf("post%0d", i));

    // LSB-first, 16-bit word
    @(negedge clk);
    s16.tvalid = 1; s16.tdata = 16'h1234; m16.tready = 1;
    #1;
    check("lsb.s_tready", 32'(s16.tready), 32'd1);
    check("lsb.tvalid0",  32'(m16.tvalid), 32'd0);
    @(negedge clk);
    s16.tvalid = 0; s16.tdata = 16'hFFFF;
    #1;
    check("lsb.b0.tdata", 32'(m16.tdata), 32'h34);
    check("lsb.b0.tlast", 32'(m16.tlast), 32'd0);
    check("lsb.b0.tvalid", 32'(m16.tvalid), 32'd1);
    @(negedge clk);
    #1;
    check("lsb.b1.tdata", 32'(m16.tdata), 32'h12);
    check("lsb.b1.tlast", 32'(m16.tlast), 32'd1);
    check("lsb.b1.s_tready", 32'(s16.tready), 32'd1);
    @(negedge clk);
    #1;
    check("lsb.end.tvalid", 32'(m16.tvalid), 32'd0);
    check("lsb.end.busy",   32'(busy16),     32'd0);

    // Single-byte words: passthrough with one cycle of latency
    @(negedge clk);
    s8.tvalid = 1; s8.tdata = 8'h5A; m8.tready = 1;
    #1;
    check("w8.a.s_tready", 32'(s8.tready), 32'd1);
    check("w8.a.tvalid",   32'(m8.tvalid), 32'd0);
    @(negedge clk);
    s8.tdata = 8'h7F;
    #1;
    check("w8.b.tdata",    32'(m8.tdata),  32'h5A);
    check("w8.b.tlast",    32'(m8.tlast),  32'd1);
    check("w8.b.s_tready", 32'(s8.tready), 32'd1);
    @(negedge clk);
    s8.tvalid = 0;
    #1;
    check("w8.c.tdata",    32'(m8.tdata),  32'h7F);
    check("w8.c.tlast",    32'(m8.tlast),  32'd1);
    check("w8.c.tvalid",   32'(m8.tvalid), 32'd1);
    check("w8.c.s_tready", 32'(s8.tready), 32'd1);
    @(negedge clk);
    #1;
    check("w8.d.tvalid",   32'(m8.tvalid), 32'd0);
    check("w8.d.busy",     32'(busy8),     32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_word_serializer.md
Name: axis_word_serializer

Overview:
- Host-facing transmit end of the processor's output stream.
- Accepts one wide AXI-Stream word per transfer on its slave port, typically driven by the processor's m_axis (OUT_WIDTH bits, byte-aligned).
- Emits that word as a sequence of bytes on a byte-wide AXI-Stream master, with tlast marking the final byte, toward the byte-oriented host link (UART/FIFO bridge).
- Sustains one byte per cycle with no bubble between consecutive words.

Parameters:
- WORD_WIDTH, 16, input word width in bits; must be a multiple of 8 and at least 8 (elaboration error otherwise).
- MSB_FIRST, 1, 1 = most-significant byte sent first; 0 = least-significant byte first.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- arstn  input  1  asynchronous active-low reset.
- s_axis_tdata  input  WORD_WIDTH  word to serialize.
- s_axis_tvalid  input  1  word valid.
- s_axis_tready  output  1  block can accept a word this cycle.
- m_axis_tdata  output  8  current byte.
- m_axis_tvalid  output  1  byte valid.
- m_axis_tready  input  1  downstream accepts byte.
- m_axis_tlast  output  1  high on the final byte of each word.
- busy  output  1  a word is held and not fully transmitted.

Behaviour:
- Reset: clk and reset are fixed: one clock, clk; reset arstn is asynchronous, active-low. While arstn is low:
  - state=IDLE, byte index=0, shift register=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0.
  - s_axis_tready=0 during reset, then 1 from the first cycle after release.
- Derived constant: NBYTES = WORD_WIDTH/8. Byte index counter width is clog2(NBYTES), minimum 1.
- States:
  - IDLE: m_axis_tvalid=0, s_axis_tready=1. On s_axis_tvalid, latch s_axis_tdata into the shift register, index=0, go to SEND.
  - SEND: m_axis_tvalid=1. m_axis_tdata is the byte currently at the output end of the shift register (MSB_FIRST: bits [WORD_WIDTH-1 -: 8]; else bits [7:0]). m_axis_tlast = (index == NBYTES-1).
- SEND transitions:
  - No handshake (m_axis_tready=0): hold all outputs stable; tdata/tlast must not change while tvalid=1 and unaccepted.
  - Handshake on a non-final byte: shift the register by 8 in the send direction, index+1.
  - Handshake on the final byte with s_axis_tvalid=1: load the new word, index=0, stay in SEND. No idle cycle.
  - Handshake on the final byte with s_axis_tvalid=0: go to IDLE.
- s_axis_tready = (state==IDLE) || (state==SEND && tlast && m_axis_tready). This is combinational from m_axis_tready; it must not depend combinationally on s_axis_tvalid.
- Latency: word accepted at edge N; first byte presented with m_axis_tvalid=1 in cycle N+1. Peak throughput is 1 byte/cycle; a word takes NBYTES cycles with continuous ready.
- busy = (state==SEND).
- NBYTES=1: every byte carries tlast=1; word-per-cycle passthrough with one cycle of latency.
- m_axis_tvalid never drops without a handshake except on reset.
- Reset mid-word: remaining bytes are discarded; the next word after reset starts at byte 0.
- s_axis_tdata is sampled only on the s-side handshake; changes at other times are ignored.

Test Plan:
- WORD_WIDTH=24, MSB_FIRST=1, m_axis_tready=1, single word 0xA1B2C3 → bytes A1, B2, C3 on three consecutive cycles starting one cycle after acceptance; tlast=1 only on C3; then tvalid=0 and s_axis_tready=1.
- Same configuration, back-to-back words 0x010203 and 0x0A0B0C, tvalid held high → six consecutive bytes 01 02 03 0A 0B 0C with no gap. s_axis_tready pulses high only in the cycles where 03 and 0C are accepted. tlast=1 on 03 and 0C.
- Backpressure: word 0xDEADBE, m_axis_tready toggling 1,0,0,1,0,1 → output DE accepted, then AD held stable for two cycles, then accepted, then BE held one cycle, then accepted. No byte is lost or duplicated; s_axis_tready=0 throughout until BE is accepted.
- MSB_FIRST=0, WORD_WIDTH=16, word 0x1234 → bytes 34 then 12; tlast on 12.
- Reset mid-word: word 0xA1B2C3, assert arstn low after A1 is accepted → tvalid=0 and busy=0 immediately, asynchronously. After release, word 0x445566 yields 44 55 66 with tlast on 66.
- WORD_WIDTH=8: words 0x5A then 0x7F back-to-back → bytes 5A, 7F on consecutive cycles, each with tlast=1; s_axis_tready=1 every cycle with continuous m_axis_tready.
